// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sine/cosine generator:
// FSM state encoding, the arctangent table generator and the CORDIC gain.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROT,
    ST_OUT
  } state_t;

  // Reciprocal of the CORDIC gain An, scaled into x0 at elaboration time.
  localparam real CORDIC_GAIN = 0.6072529350;

  // Fractional bits of the fixed-point radian values used while building the table.
  localparam int ANG_FRAC = 60;

  // atan(1/n) in radians, Q0.ANG_FRAC, by its Taylor series (n >= 2).
  function automatic longint unsigned atan_recip_q(input longint unsigned n);
    longint unsigned t;
    longint unsigned den;
    longint unsigned sum;
    logic            neg;
    t   = (64'd1 << ANG_FRAC) / n;
    den = 64'd1;
    sum = 64'd0;
    neg = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (neg) sum = sum - t / den;
      else     sum = sum + t / den;
      neg = ~neg;
      den = den + 64'd2;
      t   = t / n / n;
    end
    return sum;
  endfunction

  // pi/4 in Q0.ANG_FRAC via Machin's formula.
  function automatic longint unsigned pi_over_4_q();
    return 64'd4 * atan_recip_q(64'd5) - atan_recip_q(64'd239);
  endfunction

  // round(atan(2^-i) / (2*pi) * 2^width): binary-angle arctangent table entry.
  function automatic logic [63:0] atan_entry(input int i, input int width);
    longint unsigned a;
    longint unsigned d;
    longint unsigned r;
    longint unsigned q;
    d = 64'd8 * pi_over_4_q();
    if (i == 0)             a = pi_over_4_q();
    else if (i >= ANG_FRAC) a = 64'd0;
    else                    a = atan_recip_q(64'd1 << i);
    // Restoring division yields one extra fraction bit for the final round.
    r = a;
    q = 64'd0;
    for (int k = 0; k <= width; k++) begin
      r = r << 1;
      q = q << 1;
      if (r >= d) begin
        r = r - d;
        q = q | 64'd1;
      end
    end
    return (q + 64'd1) >> 1;
  endfunction

endpackage

// File: rtl/cordic_sincos_axis_if.sv
// AXI4-Stream style valid/ready/data bundle with producer and consumer views.
interface cordic_sincos_axis_if #(
  parameter int W = 16
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/cordic_microrot.sv
// One CORDIC micro-rotation in rotation mode: steer towards z = 0 using
// arithmetic shifts by i and the binary-angle arctangent table.
module cordic_microrot
  import cordic_pkg::*;
#(
  parameter int W    = 18,
  parameter int ITER = 16,
  parameter int CW   = 4
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [W-1:0]  z,
  input  logic        [CW-1:0] i,
  output logic signed [W-1:0]  x_next,
  output logic signed [W-1:0]  y_next,
  output logic signed [W-1:0]  z_next
);

  logic [W-1:0] atan_rom [ITER];

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    localparam logic [W-1:0] ATAN_G = W'(atan_entry(g, W));
    assign atan_rom[g] = ATAN_G;
  end

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;
  logic signed [W-1:0] z_step;

  // Select the rotation direction from the sign of the residual angle.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave a value held (latch).
    x_next = x;
    y_next = y;
    z_next = z;
    x_sh   = x >>> i;
    y_sh   = y >>> i;
    z_step = $signed(atan_rom[i]);
    if (z[W-1]) begin
      x_next = x + y_sh;
      y_next = y - x_sh;
      z_next = z + z_step;
    end else begin
      x_next = x - y_sh;
      y_next = y + x_sh;
      z_next = z - z_step;
    end
  end

endmodule

// File: rtl/cordic_sincos_axis.sv
// Iterative CORDIC sine/cosine generator with stream handshakes on both sides.
// Optional gain compensation: define CORDIC_SINCOS_GAIN_COMP_EN to pre-scale x0
// by 1/An so the outputs are unit-amplitude; otherwise outputs carry gain An.
module cordic_sincos_axis
  import cordic_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ITER   = 16,
  parameter int GUARD  = 2
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  cordic_sincos_axis_if.slave  s,
  cordic_sincos_axis_if.master m
);

  localparam int IW      = DATA_W + GUARD;
  localparam int CW      = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int ROUND_C = (GUARD == 0) ? 0 : (1 << (GUARD - 1));

`ifdef CORDIC_SINCOS_GAIN_COMP_EN
  localparam longint X_INIT_L = longint'(CORDIC_GAIN * (2.0 ** (DATA_W - 2 + GUARD)));
`else
  localparam longint X_INIT_L = longint'(1) << (DATA_W - 2 + GUARD);
`endif
  localparam logic signed [IW-1:0] X_INIT  = IW'(X_INIT_L);
  localparam logic signed [IW:0]   SAT_MAX = (IW + 1)'((longint'(1) << (DATA_W - 1)) - 1);
  localparam logic signed [IW:0]   SAT_MIN = ~SAT_MAX;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic signed [IW-1:0]    x_r, y_r, z_r;
  logic signed [IW-1:0]    x_n, y_n, z_n;
  logic                    neg_r;
  logic                    tvalid_r;
  logic [2*DATA_W-1:0]     tdata_r;
  logic [1:0]              quad;
  logic                    fold;
  logic [DATA_W-1:0]       phase_f;
  logic signed [IW-1:0]    z_init;
  logic                    accept;

  assign s.tready = (state == ST_IDLE);
  assign m.tvalid = tvalid_r;
  assign m.tdata  = tdata_r;
  assign accept   = (state == ST_IDLE) && s.tvalid;

  // Quadrants 01/10 are rotated by pi into [-pi/2, pi/2) and negated at the end.
  assign quad    = s.tdata[DATA_W-1 -: 2];
  assign fold    = (quad == 2'b01) || (quad == 2'b10);
  assign phase_f = fold ? (s.tdata ^ {1'b1, {(DATA_W - 1){1'b0}}}) : s.tdata;
  assign z_init  = IW'(phase_f) << GUARD;

  cordic_microrot #(
    .W    (IW),
    .ITER (ITER),
    .CW   (CW)
  ) u_microrot (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .i      (cnt),
    .x_next (x_n),
    .y_next (y_n),
    .z_next (z_n)
  );

  // Drop guard bits with round-half-up, apply the fold negation, then clamp.
  function automatic logic [DATA_W-1:0] finish_comp(input logic signed [IW-1:0] v,
                                                     input logic negate);
    logic signed [IW:0] ext;
    logic signed [IW:0] rnd;
    logic signed [IW:0] sgn;
    ext = {v[IW-1], v};
    rnd = (ext + (IW + 1)'(ROUND_C)) >>> GUARD;
    sgn = negate ? -rnd : rnd;
    if (sgn > SAT_MAX)      sgn = SAT_MAX;
    else if (sgn < SAT_MIN) sgn = SAT_MIN;
    return sgn[DATA_W-1:0];
  endfunction

  // Control FSM: accept, iterate ITER times, then hold the result until taken.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!aresetn) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      tvalid_r <= 1'b0;
      tdata_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s.tvalid) begin
            cnt   <= '0;
            state <= ST_ROT;
          end
        end
        ST_ROT: begin
          if (cnt == CW'(ITER - 1)) begin
            tdata_r  <= {finish_comp(y_n, neg_r), finish_comp(x_n, neg_r)};
            tvalid_r <= 1'b1;
            cnt      <= '0;
            state    <= ST_OUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_OUT: begin
          if (m.tready) begin
            tvalid_r <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Rotation datapath: load the folded start vector, then step once per ROT cycle.
  always_ff @(posedge aclk) begin
    // NOTE: no reset here; these registers are always loaded on accept before anything reads them.
    if (accept) begin
      x_r   <= X_INIT;
      y_r   <= '0;
      z_r   <= z_init;
      neg_r <= fold;
    end else if (state == ST_ROT) begin
      x_r <= x_n;
      y_r <= y_n;
      z_r <= z_n;
    end
  end

endmodule

// File: tb/tb_cordic_sincos_axis.sv
// Directed bench for cordic_sincos_axis: table of phases with expected
// (sin, cos), plus backpressure, streaming-rate and mid-rotation reset cases.
module tb_cordic_sincos_axis;

  localparam int DATA_W = 16;
  localparam int ITER   = 16;
  localparam int GUARD  = 2;
  localparam int TOL    = 4;

`ifdef CORDIC_SINCOS_GAIN_COMP_EN
  localparam int AMP  = 16384;  // 1.0 in Q1.14
  localparam int DIAG = 11585;  // 16384 * cos(pi/4)
  localparam int TINY = 2;      // 16384 * sin(2*pi/65536), rounded
`else
  localparam int AMP  = 26981;  // 16384 * An
  localparam int DIAG = 19078;  // 26980.5 * cos(pi/4)
  localparam int TINY = 3;      // 26980.5 * sin(2*pi/65536), rounded
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  cordic_sincos_axis_if #(.W(DATA_W))     s_axis ();
  cordic_sincos_axis_if #(.W(2 * DATA_W)) m_axis ();

  cordic_sincos_axis #(
    .DATA_W (DATA_W),
    .ITER   (ITER),
    .GUARD  (GUARD)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s       (s_axis),
    .m       (m_axis)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int xfers  = 0;
  int xfer_cyc[$];

  // Count output transfers and remember the cycle each one happened in.
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (aresetn && m_axis.tvalid && m_axis.tready) begin
      xfers <= xfers + 1;
      xfer_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp, input int tol);
    int diff;
    n_vec++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Offer one phase, wait (bounded) for m_tvalid and return the result.
  task automatic run_sample(input logic [DATA_W-1:0] phase, input string tag,
                            output int sin_o, output int cos_o);
    int lat;
    @(negedge aclk);
    check({tag, " s_tready before accept"}, longint'(s_axis.tready), 1);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = phase;
    @(posedge aclk);
    @(negedge aclk);
    s_axis.tvalid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge aclk);
      if (m_axis.tvalid) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency (-1 = timeout)"}, lat, ITER);
    sin_o = int'($signed(m_axis.tdata[2*DATA_W-1:DATA_W]));
    cos_o = int'($signed(m_axis.tdata[DATA_W-1:0]));
  endtask

  typedef struct {
    string             name;
    logic [DATA_W-1:0] phase;
    int                sin_e;
    int                cos_e;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int                  s_v, c_v;
    int                  x0;
    logic [2*DATA_W-1:0] held;
    logic                seen;

    vecs[0] = '{"ph0000", 16'h0000, 0,     AMP};
    vecs[1] = '{"ph4000", 16'h4000, AMP,   0};
    vecs[2] = '{"ph8000", 16'h8000, 0,     -AMP};
    vecs[3] = '{"phC000", 16'hC000, -AMP,  0};
    vecs[4] = '{"ph2000", 16'h2000, DIAG,  DIAG};
    vecs[5] = '{"ph6000", 16'h6000, DIAG,  -DIAG};
    vecs[6] = '{"phA000", 16'hA000, -DIAG, -DIAG};
    vecs[7] = '{"phFFFF", 16'hFFFF, -TINY, AMP};

    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    m_axis.tready = 1'b1;

    // Reset state.
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset m_tvalid", longint'(m_axis.tvalid), 0);
    check("reset m_tdata", longint'(m_axis.tdata), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("post-reset s_tready", longint'(s_axis.tready), 1);
    check("post-reset m_tvalid", longint'(m_axis.tvalid), 0);

    // Table of phases, m_tready held high.
    for (int v = 0; v < 8; v++) begin
      run_sample(vecs[v].phase, vecs[v].name, s_v, c_v);
      check_near({vecs[v].name, " sin"}, s_v, vecs[v].sin_e, TOL);
      check_near({vecs[v].name, " cos"}, c_v, vecs[v].cos_e, TOL);
      @(negedge aclk);
      check({vecs[v].name, " m_tvalid after transfer"}, longint'(m_axis.tvalid), 0);
      check({vecs[v].name, " s_tready after transfer"}, longint'(s_axis.tready), 1);
    end

    // Backpressure: 10 stalled cycles, s_tvalid offered but ignored.
    m_axis.tready = 1'b0;
    run_sample(16'h4000, "stall", s_v, c_v);
    check_near("stall sin", s_v, AMP, TOL);
    check_near("stall cos", c_v, 0, TOL);
    held = m_axis.tdata;
    x0   = xfers;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      check("stall m_tvalid", longint'(m_axis.tvalid), 1);
      check("stall m_tdata stable", longint'(m_axis.tdata), longint'(held));
      check("stall s_tready", longint'(s_axis.tready), 0);
    end
    s_axis.tvalid = 1'b0;
    m_axis.tready = 1'b1;
    @(negedge aclk);
    check("release m_tvalid", longint'(m_axis.tvalid), 0);
    check("release s_tready (IDLE)", longint'(s_axis.tready), 1);
    repeat (3) @(negedge aclk);
    check("release transfer count", xfers - x0, 1);

    // Streaming with s_tvalid and m_tready held high: one result per ITER+2 cycles.
    xfer_cyc.delete();
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 16'h0000;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (xfer_cyc.size() >= 3) break;
    end
    s_axis.tvalid = 1'b0;
    check("stream transfers seen", longint'(xfer_cyc.size() >= 3), 1);
    if (xfer_cyc.size() >= 3) begin
      check("stream spacing 1", xfer_cyc[1] - xfer_cyc[0], ITER + 2);
      check("stream spacing 2", xfer_cyc[2] - xfer_cyc[1], ITER + 2);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge aclk);
      if (s_axis.tready && !m_axis.tvalid) break;
    end

    // Reset while iteration 7 is being computed: the sample is dropped.
    @(negedge aclk);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 16'h4000;
    @(posedge aclk);
    @(negedge aclk);
    s_axis.tvalid = 1'b0;
    repeat (7) @(negedge aclk);
    x0      = xfers;
    seen    = 1'b0;
    aresetn = 1'b0;
    repeat (2) begin
      @(negedge aclk);
      seen = seen | m_axis.tvalid;
    end
    aresetn = 1'b1;
    @(negedge aclk);
    check("abort s_tready", longint'(s_axis.tready), 1);
    check("abort m_tdata", longint'(m_axis.tdata), 0);
    for (int k = 0; k < 25; k++) begin
      @(negedge aclk);
      seen = seen | m_axis.tvalid;
    end
    check("abort no m_tvalid", longint'(seen), 0);
    check("abort no transfer", xfers - x0, 0);

    run_sample(16'h0000, "after-abort", s_v, c_v);
    check_near("after-abort sin", s_v, 0, TOL);
    check_near("after-abort cos", c_v, AMP, TOL);
    @(negedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
